// File: rtl/difftest_pkg.sv
// Shared types for the LR/SC difftest event path: queue entry layout and counter widths.
// Entry fields are sized for the widest legal configuration; modules slice down to their parameters.
package difftest_pkg;

  localparam int SEQ_W        = 16;
  localparam int DROP_W       = 16;
  localparam int COREID_MAX_W = 32;
  localparam int CHAN_MAX_W   = 4;

  typedef struct packed {
    logic                    success;
    logic [COREID_MAX_W-1:0] coreid;
    logic [CHAN_MAX_W-1:0]   chan;
    logic [SEQ_W-1:0]        seq;
  } lrsc_event_t;

  // Channel index width; a single channel still needs one bit on the port.
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/difftest_lrsc_event_queue_if.sv
// Event capture strobes from the harts plus the valid/ready queue head toward the checker.
// master = producer/consumer side, slave = the event queue.
interface difftest_lrsc_event_queue_if
  import difftest_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int COREID_W = 8
) ();

  localparam int CHAN_W = chan_width(NUM_CH);

  logic [NUM_CH-1:0]          io_valid;
  logic [NUM_CH-1:0]          io_success;
  logic [NUM_CH*COREID_W-1:0] io_coreid;

  logic                       out_valid;
  logic                       out_ready;
  logic                       out_success;
  logic [COREID_W-1:0]        out_coreid;
  logic [CHAN_W-1:0]          out_chan;
  logic [SEQ_W-1:0]           out_seq;

  modport master (
    output io_valid,
    output io_success,
    output io_coreid,
    output out_ready,
    input  out_valid,
    input  out_success,
    input  out_coreid,
    input  out_chan,
    input  out_seq
  );

  modport slave (
    input  io_valid,
    input  io_success,
    input  io_coreid,
    input  out_ready,
    output out_valid,
    output out_success,
    output out_coreid,
    output out_chan,
    output out_seq
  );

endinterface

// File: rtl/difftest_rr_arbiter.sv
// Round-robin pick of one requester per cycle; combinational grant, pointer moves past the winner.
// en low suppresses the grant and freezes the pointer.
module difftest_rr_arbiter
  import difftest_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CHAN_W = chan_width(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [CHAN_W-1:0] gnt_idx,
  output logic              gnt_vld
);

  logic [CHAN_W-1:0] rr_ptr;

  // First pass looks at or after the pointer, second pass wraps to the bottom.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    if (en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!gnt_vld && req[i] && (i >= int'(rr_ptr))) begin
          gnt[i]  = 1'b1;
          gnt_idx = CHAN_W'(i);
          gnt_vld = 1'b1;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!gnt_vld && req[i]) begin
          gnt[i]  = 1'b1;
          gnt_idx = CHAN_W'(i);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CHAN_W'(1);
    end
  end

endmodule

// File: rtl/difftest_lrsc_event_queue.sv
// Per-channel LR/SC capture registers merged round-robin into an in-order FIFO; event to out_valid is 2 edges.
// A busy, ungranted capture register drops new events (counted); a full FIFO stalls grants unless the head pops.
module difftest_lrsc_event_queue
  import difftest_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int DEPTH    = 8,
  parameter  int COREID_W = 8,
  localparam int CHAN_W   = chan_width(NUM_CH),
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  difftest_lrsc_event_queue_if.slave lrsc,
  output logic [DROP_W-1:0]         drop_count,
  output logic [ADDR_W:0]           level
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [NUM_CH-1:0]   cap_vld;
  logic [NUM_CH-1:0]   cap_success;
  logic [COREID_W-1:0] cap_coreid [NUM_CH];

  logic [NUM_CH-1:0]   arm;
  logic [NUM_CH-1:0]   take;
  logic [NUM_CH-1:0]   drop;
  logic [NUM_CH-1:0]   gnt;
  logic [CHAN_W-1:0]   gnt_idx;
  logic                gnt_vld;

  logic                space_ok;
  logic                push;
  logic                pop;

  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [SEQ_W-1:0]    seq;
  lrsc_event_t         fifo_mem [DEPTH];
  lrsc_event_t         wr_entry;
  lrsc_event_t         head;

  logic [4:0]          drop_num;
  logic [DROP_W:0]     drop_sum;
  logic                unused_head_bits;

  // ---------------------------------------------------------------- capture
  assign arm  = lrsc.io_valid & {NUM_CH{enable}};
  // A register being granted this cycle frees up in time to take the new event.
  assign take = arm & (~cap_vld | gnt);
  assign drop = arm & cap_vld & ~gnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_vld     <= '0;
      cap_success <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cap_coreid[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (take[i]) begin
          cap_vld[i]     <= 1'b1;
          cap_success[i] <= lrsc.io_success[i];
          cap_coreid[i]  <= lrsc.io_coreid[i*COREID_W +: COREID_W];
        end else if (gnt[i]) begin
          cap_vld[i]     <= 1'b0;
        end
      end
    end
  end

  // ------------------------------------------------------------ arbitration
  // Full is tolerated only when the head leaves in the same cycle.
  assign pop      = lrsc.out_valid && lrsc.out_ready;
  assign space_ok = (level < FULL_LEVEL) || pop;
  assign push     = gnt_vld;

  difftest_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (cap_vld),
    .en      (space_ok),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    wr_entry      = '0;
    wr_entry.chan = CHAN_MAX_W'(gnt_idx);
    wr_entry.seq  = seq;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        wr_entry.success = cap_success[i];
        wr_entry.coreid  = COREID_MAX_W'(cap_coreid[i]);
      end
    end
  end

  // ------------------------------------------------------------------- fifo
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      seq    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        seq    <= seq + SEQ_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push && !pop) begin
        level <= level + (ADDR_W + 1)'(1);
      end else if (!push && pop) begin
        level <= level - (ADDR_W + 1)'(1);
      end
    end
  end

  assign head             = fifo_mem[rd_ptr];
  assign lrsc.out_valid   = (level != '0);
  assign lrsc.out_success = head.success;
  assign lrsc.out_coreid  = head.coreid[COREID_W-1:0];
  assign lrsc.out_chan    = head.chan[CHAN_W-1:0];
  assign lrsc.out_seq     = head.seq;
  assign unused_head_bits = ^{head.coreid, head.chan};

  // ------------------------------------------------------------ drop count
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_num = drop_num + 5'(drop[i]);
    end
    drop_sum = {1'b0, drop_count} + (DROP_W + 1)'(drop_num);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_sum[DROP_W]) begin
      drop_count <= '1;
    end else begin
      drop_count <= drop_sum[DROP_W-1:0];
    end
  end

endmodule

// File: tb/tb_difftest_lrsc_event_queue.sv
// Drives random and directed LR/SC traffic and compares every cycle against a queue-based reference model.
module tb_difftest_lrsc_event_queue;
  import difftest_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int DEPTH    = 8;
  localparam int COREID_W = 8;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     enable;
  logic [DROP_W-1:0]        drop_count;
  logic [$clog2(DEPTH):0]   level;

  difftest_lrsc_event_queue_if #(.NUM_CH(NUM_CH), .COREID_W(COREID_W)) bus ();

  difftest_lrsc_event_queue #(
    .NUM_CH   (NUM_CH),
    .DEPTH    (DEPTH),
    .COREID_W (COREID_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .lrsc       (bus),
    .drop_count (drop_count),
    .level      (level)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit succ;
    int core;
    int chan;
    int seq;
  } ref_ev_t;

  ref_ev_t m_q[$];
  bit      m_cap_vld  [NUM_CH];
  bit      m_cap_succ [NUM_CH];
  int      m_cap_core [NUM_CH];
  int      m_rr;
  int      m_seq;
  int      m_drop;

  int      n_vec;
  int      n_bad;
  int      obs_chan[$];
  int      obs_seq[$];
  int      last_pop_seq;
  bit      saw_wrap;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cap_vld[i]  = 1'b0;
      m_cap_succ[i] = 1'b0;
      m_cap_core[i] = 0;
    end
    m_rr   = 0;
    m_seq  = 0;
    m_drop = 0;
  endtask

  // One clock edge of the intended behaviour, evaluated from the inputs now on the bus.
  task automatic model_step();
    bit      pop;
    bit      space;
    int      g;
    int      cand;
    ref_ev_t e;
    ref_ev_t gone;
    pop   = (m_q.size() != 0) && bus.out_ready;
    space = (m_q.size() < DEPTH) || pop;
    g     = -1;
    e     = '{succ: 1'b0, core: 0, chan: 0, seq: 0};
    if (space) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cand = (m_rr + k) % NUM_CH;
        if (g < 0 && m_cap_vld[cand]) g = cand;
      end
    end
    if (g >= 0) e = '{succ: m_cap_succ[g], core: m_cap_core[g], chan: g, seq: m_seq};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (enable && bus.io_valid[ch]) begin
        if (m_cap_vld[ch] && ch != g) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          m_cap_vld[ch]  = 1'b1;
          m_cap_succ[ch] = bus.io_success[ch];
          m_cap_core[ch] = int'(bus.io_coreid[ch*COREID_W +: COREID_W]);
        end
      end else if (ch == g) begin
        m_cap_vld[ch] = 1'b0;
      end
    end
    if (pop) gone = m_q.pop_front();
    if (g >= 0) begin
      m_q.push_back(e);
      m_seq = (m_seq + 1) % 65536;
      m_rr  = (g + 1) % NUM_CH;
    end
  endtask

  task automatic compare_all();
    check_val("level", 32'(level), 32'(m_q.size()));
    check_val("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    check_val("drop_count", 32'(drop_count), 32'(m_drop));
    if (m_q.size() != 0) begin
      check_val("out_success", 32'(bus.out_success), 32'(m_q[0].succ));
      check_val("out_coreid", 32'(bus.out_coreid), 32'(m_q[0].core));
      check_val("out_chan", 32'(bus.out_chan), 32'(m_q[0].chan));
      check_val("out_seq", 32'(bus.out_seq), 32'(m_q[0].seq));
    end
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge after checking.
  task automatic tick();
    if (bus.out_valid && bus.out_ready) begin
      obs_chan.push_back(int'(bus.out_chan));
      obs_seq.push_back(int'(bus.out_seq));
      if (last_pop_seq == 65535 && bus.out_seq == 16'h0000) saw_wrap = 1'b1;
      last_pop_seq = int'(bus.out_seq);
    end
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic reset_dut();
    #2 reset = 1'b1;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    enable         = 1'b1;
    bus.io_valid   = '0;
    bus.io_success = '0;
    bus.io_coreid  = '0;
    bus.out_ready  = 1'b0;
    n_vec          = 0;
    n_bad          = 0;
    last_pop_seq   = -1;
    saw_wrap       = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b0;

    // single event on ch2: visible two edges after capture
    repeat (3) tick();
    bus.io_valid   = 4'b0100;
    bus.io_success = 4'b0100;
    bus.io_coreid  = 32'h0005_0000;
    tick();
    check_val("single_lat1_valid", 32'(bus.out_valid), 32'd0);
    bus.io_valid = '0;
    tick();
    check_val("single_valid", 32'(bus.out_valid), 32'd1);
    check_val("single_chan", 32'(bus.out_chan), 32'd2);
    check_val("single_coreid", 32'(bus.out_coreid), 32'h05);
    check_val("single_success", 32'(bus.out_success), 32'd1);
    check_val("single_seq", 32'(bus.out_seq), 32'd0);

    // all channels at once drain in index order
    reset_dut();
    bus.out_ready = 1'b1;
    obs_chan.delete();
    obs_seq.delete();
    bus.io_valid   = 4'b1111;
    bus.io_success = 4'b1010;
    bus.io_coreid  = 32'h1312_1110;
    tick();
    bus.io_valid = '0;
    repeat (8) tick();
    check_val("burst_count", 32'(obs_chan.size()), 32'd4);
    for (int i = 0; i < obs_chan.size() && i < 4; i++) begin
      check_val("burst_chan", 32'(obs_chan[i]), 32'(i));
      check_val("burst_seq", 32'(obs_seq[i]), 32'(i));
    end
    check_val("burst_drop", 32'(drop_count), 32'd0);

    // fill to DEPTH, one more parks in the capture register, the rest drop
    reset_dut();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.io_valid  = 4'b0001;
      bus.io_coreid = 32'(k);
      tick();
      bus.io_valid = '0;
      tick();
    end
    check_val("full_level", 32'(level), 32'd8);
    check_val("full_drop", 32'(drop_count), 32'd3);
    bus.out_ready = 1'b1;
    repeat (14) tick();
    check_val("full_drained", 32'(level), 32'd0);

    // capture disabled
    reset_dut();
    enable       = 1'b0;
    bus.io_valid = 4'b1111;
    repeat (5) tick();
    check_val("dis_level", 32'(level), 32'd0);
    check_val("dis_drop", 32'(drop_count), 32'd0);
    bus.io_valid = '0;
    enable       = 1'b1;
    tick();
    check_val("dis_after_level", 32'(level), 32'd0);

    // reset with events queued
    reset_dut();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.io_valid = 4'b0010;
      tick();
      bus.io_valid = '0;
      tick();
    end
    check_val("pre_rst_level", 32'(level), 32'd5);
    reset_dut();
    check_val("post_rst_level", 32'(level), 32'd0);
    check_val("post_rst_valid", 32'(bus.out_valid), 32'd0);
    bus.io_valid = 4'b0001;
    tick();
    bus.io_valid = '0;
    tick();
    check_val("post_rst_seq", 32'(bus.out_seq), 32'd0);

    // randomized traffic with alternating backpressure phases and rare resets
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      enable         = ($urandom_range(0, 9) != 0);
      bus.io_valid   = 4'($urandom) & 4'($urandom | $urandom);
      bus.io_success = 4'($urandom);
      bus.io_coreid  = $urandom;
      bus.out_ready  = ($urandom_range(0, 99) < (((c / 500) % 2 == 1) ? 20 : 85));
      if ($urandom_range(0, 499) == 0) reset_dut();
      else tick();
    end

    // long saturating run: seq wraps and drop_count pins at max
    bus.io_valid = '0;
    reset_dut();
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    bus.io_valid  = 4'b1111;
    last_pop_seq  = -1;
    saw_wrap      = 1'b0;
    for (int c = 0; c < 65545; c++) begin
      bus.io_coreid  = $urandom;
      bus.io_success = 4'($urandom);
      tick();
    end
    check_val("sat_drop", 32'(drop_count), 32'h0000_FFFF);
    check_val("seq_wrap_seen", 32'(saw_wrap), 32'd1);
    bus.io_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
